// File: rtl/regfile_pkg.sv
// Shared constants and width helpers for the multi-ported register file.
package regfile_pkg;

   localparam int DEF_DATA_WIDTH_POW = 6;
   localparam int DEF_REG_COUNT      = 32;
   localparam int DEF_NUM_RD         = 2;
   localparam int DEF_NUM_WR         = 2;
   localparam int DEF_BYPASS         = 1;

   // Width of a register index.
   function automatic int calc_addr_w(input int reg_count);
      return (reg_count <= 2) ? 1 : $clog2(reg_count);
   endfunction

   // Width of a counter able to hold 0..reg_count inclusive.
   function automatic int calc_cnt_w(input int reg_count);
      return $clog2(reg_count + 1);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending (busy) tracking plus a registered count of pending registers.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int REG_COUNT = DEF_REG_COUNT,
   parameter int NUM_RD    = DEF_NUM_RD,
   parameter int NUM_WR    = DEF_NUM_WR,
   parameter int ADDR_W    = calc_addr_w(DEF_REG_COUNT),
   parameter int CNT_W     = calc_cnt_w(DEF_REG_COUNT)
) (
   input  logic                           clk_in,
   input  logic                           reset,
   input  logic [NUM_WR-1:0]              wr_valid,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_idx,
   input  logic                           issue_valid,
   input  logic [ADDR_W-1:0]              issue_rd,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  rs_idx,
   input  logic [NUM_RD-1:0]              rd_fwd_hit,
   output logic [NUM_RD-1:0]              busy_out,
   output logic [CNT_W-1:0]               pending_count_out
);

   localparam logic [ADDR_W:0] RC_L = (ADDR_W + 1)'(REG_COUNT);

   logic [REG_COUNT-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 issue_ok;

   // Next busy vector: writes clear, issue sets afterwards so issue wins; x0 never pending.
   always_comb begin
      busy_d   = busy_q;
      issue_ok = issue_valid && (issue_rd != '0) && ({1'b0, issue_rd} < RC_L);
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_valid[i]) busy_d[wr_idx[i]] = 1'b0;
      end
      if (issue_ok) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
      count_d = '0;
      for (int k = 1; k < REG_COUNT; k++) begin
         count_d = count_d + CNT_W'(busy_d[k]);
      end
   end

   // Busy bits and population count, both cleared by reset.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   // Busy lookup per read port, hidden when the same-cycle write forwards the value.
   always_comb begin
      for (int j = 0; j < NUM_RD; j++) begin
         busy_out[j] = 1'b0;
         if ({1'b0, rs_idx[j]} < RC_L) busy_out[j] = busy_q[rs_idx[j]] & ~rd_fwd_hit[j];
      end
   end

   assign pending_count_out = count_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with optional write-to-read forwarding and a pending scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH_POW = DEF_DATA_WIDTH_POW,
   parameter int DATA_WIDTH     = 1 << DATA_WIDTH_POW,
   parameter int REG_COUNT      = DEF_REG_COUNT,
   parameter int NUM_RD         = DEF_NUM_RD,
   parameter int NUM_WR         = DEF_NUM_WR,
   parameter int BYPASS         = DEF_BYPASS,
   localparam int ADDR_W        = calc_addr_w(REG_COUNT),
   localparam int CNT_W         = calc_cnt_w(REG_COUNT)
) (
   input  logic                              clk_in,
   input  logic                              reset,
   input  logic [NUM_WR-1:0]                 regWrite_ctrl,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]     rd_in,
   input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] writeData_in,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]     rs_in,
   output logic [NUM_RD-1:0][DATA_WIDTH-1:0] regData_out,
   input  logic                              issue_valid,
   input  logic [ADDR_W-1:0]                 issue_rd,
   output logic [NUM_RD-1:0]                 busy_out,
   output logic [CNT_W-1:0]                  pending_count_out
);

   localparam logic [ADDR_W:0] RC_L = (ADDR_W + 1)'(REG_COUNT);

   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic [NUM_WR-1:0]     wr_valid;
   logic [NUM_RD-1:0]     fwd_hit;

   // A write is effective only for a nonzero, in-range destination.
   always_comb begin
      for (int i = 0; i < NUM_WR; i++) begin
         wr_valid[i] = regWrite_ctrl[i] && (rd_in[i] != '0) && ({1'b0, rd_in[i]} < RC_L);
      end
   end

   // Next register contents; ascending port order lets the highest port win a conflict.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_valid[i]) regs_d[rd_in[i]] = writeData_in[i];
      end
      regs_d[0] = '0;
   end

   // Register storage, cleared by reset regardless of concurrent writes.
   always_ff @(posedge clk_in) begin
      if (reset) regs_q <= '{default: '0};
      else       regs_q <= regs_d;
   end

   // Combinational read with optional forwarding from this cycle's writes.
   always_comb begin
      for (int j = 0; j < NUM_RD; j++) begin
         regData_out[j] = '0;
         fwd_hit[j]     = 1'b0;
         if ((rs_in[j] != '0) && ({1'b0, rs_in[j]} < RC_L)) regData_out[j] = regs_q[rs_in[j]];
         if (BYPASS != 0) begin
            for (int i = 0; i < NUM_WR; i++) begin
               if (wr_valid[i] && (rd_in[i] == rs_in[j])) begin
                  regData_out[j] = writeData_in[i];
                  fwd_hit[j]     = 1'b1;
               end
            end
         end
      end
   end

   regfile_scoreboard #(
      .REG_COUNT (REG_COUNT),
      .NUM_RD    (NUM_RD),
      .NUM_WR    (NUM_WR),
      .ADDR_W    (ADDR_W),
      .CNT_W     (CNT_W)
   ) u_scoreboard (
      .clk_in            (clk_in),
      .reset             (reset),
      .wr_valid          (wr_valid),
      .wr_idx            (rd_in),
      .issue_valid       (issue_valid),
      .issue_rd          (issue_rd),
      .rs_idx            (rs_in),
      .rd_fwd_hit        (fwd_hit),
      .busy_out          (busy_out),
      .pending_count_out (pending_count_out)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor compares them.
module tb_regfile_mp;

   localparam int DW = 64;

   logic                clk = 1'b0;
   logic                reset;
   logic [1:0]          regWrite_ctrl;
   logic [1:0][4:0]     rd_in;
   logic [1:0][DW-1:0]  writeData_in;
   logic [1:0][4:0]     rs_in;
   logic                issue_valid;
   logic [4:0]          issue_rd;
   logic [1:0][DW-1:0]  rdata_b, rdata_n;
   logic [1:0]          busy_b, busy_n;
   logic [5:0]          cnt_b, cnt_n;

   regfile_mp #(.BYPASS(1)) dut (
      .clk_in(clk), .reset(reset), .regWrite_ctrl(regWrite_ctrl), .rd_in(rd_in),
      .writeData_in(writeData_in), .rs_in(rs_in), .regData_out(rdata_b),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_out(busy_b),
      .pending_count_out(cnt_b));

   regfile_mp #(.BYPASS(0)) dut_nb (
      .clk_in(clk), .reset(reset), .regWrite_ctrl(regWrite_ctrl), .rd_in(rd_in),
      .writeData_in(writeData_in), .rs_in(rs_in), .regData_out(rdata_n),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_out(busy_n),
      .pending_count_out(cnt_n));

   always #5 clk = ~clk;

   // kind: 0 data(bypass) 1 data(no bypass) 2 busy(bypass) 3 busy(no bypass) 4 count
   typedef struct {
      string       name;
      int          kind;
      int          port;
      logic [63:0] val;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void expect_v(int kind, int port, logic [63:0] v, string nm);
      exp_t e;
      e.name = nm; e.kind = kind; e.port = port; e.val = v; e.cyc = cyc;
      exp_q.push_back(e);
   endfunction

   // Monitor: pops every expectation due this cycle and compares it with the DUT.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] act;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         case (e.kind)
            0: act = rdata_b[e.port];
            1: act = rdata_n[e.port];
            2: act = 64'(busy_b[e.port]);
            3: act = 64'(busy_n[e.port]);
            default: act = 64'(cnt_b);
         endcase
         total++;
         if (e.cyc != cyc || act !== e.val)
            $display("FAIL %s port%0d: got 0x%0h expected 0x%0h (cycle %0d/%0d)",
                     e.name, e.port, act, e.val, cyc, e.cyc);
         else
            passed++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      regWrite_ctrl = '0;
      issue_valid   = 1'b0;
      issue_rd      = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle();
      rd_in = '0; writeData_in = '0; rs_in = '0;
      step(); step();
      reset = 1'b0;
      rs_in[0] = 5'd17; rs_in[1] = 5'd31;
      #1;
      total++;
      if (cnt_b !== 6'd0 || rdata_b[0] !== 64'h0 || rdata_n[1] !== 64'h0)
         $display("FAIL direct_rst: cnt=%0d rd0=0x%0h rd1_nb=0x%0h", cnt_b, rdata_b[0], rdata_n[1]);
      else
         passed++;

      // All indices read zero after reset
      for (int k = 0; k < 32; k++) begin
         rs_in[0] = 5'(k); rs_in[1] = 5'(31 - k);
         expect_v(0, 0, 64'h0, "rst_rd0");
         expect_v(0, 1, 64'h0, "rst_rd1");
         expect_v(1, 0, 64'h0, "rst_rd_nb");
         if (k == 0) begin
            expect_v(4, 0, 64'h0, "rst_cnt");
            expect_v(2, 0, 64'h0, "rst_busy0");
            expect_v(2, 1, 64'h0, "rst_busy1");
         end
         step();
      end

      // Both ports write x5; port 1 wins
      regWrite_ctrl = 2'b11; rd_in[0] = 5'd5; rd_in[1] = 5'd5;
      writeData_in[0] = 64'hA5A5; writeData_in[1] = 64'h1234;
      rs_in[0] = 5'd5; rs_in[1] = 5'd0;
      expect_v(0, 0, 64'h1234, "conf_byp");
      expect_v(1, 0, 64'h0, "conf_nobyp");
      step(); idle();
      rs_in[0] = 5'd5; rs_in[1] = 5'd5;
      expect_v(0, 0, 64'h1234, "conf_rd0");
      expect_v(0, 1, 64'h1234, "conf_rd1");
      expect_v(1, 0, 64'h1234, "conf_rd_nb");
      #1;
      total++;
      if (rdata_b[1] !== 64'h1234 || rdata_n[1] !== 64'h1234)
         $display("FAIL direct_conf: got 0x%0h / 0x%0h expected 0x1234", rdata_b[1], rdata_n[1]);
      else
         passed++;
      step();

      // Same-cycle forwarding of x7
      regWrite_ctrl = 2'b01; rd_in[0] = 5'd7; writeData_in[0] = 64'hDEAD;
      rs_in[0] = 5'd7; rs_in[1] = 5'd5;
      expect_v(0, 0, 64'hDEAD, "fwd_x7");
      expect_v(1, 0, 64'h0, "nofwd_x7");
      expect_v(0, 1, 64'h1234, "fwd_other");
      #1;
      total++;
      if (rdata_b[0] !== 64'hDEAD || rdata_n[0] !== 64'h0)
         $display("FAIL direct_fwd: byp=0x%0h nobyp=0x%0h", rdata_b[0], rdata_n[0]);
      else
         passed++;
      step(); idle();
      expect_v(0, 0, 64'hDEAD, "x7_rd");
      expect_v(1, 0, 64'hDEAD, "x7_rd_nb");
      step();
      regWrite_ctrl = 2'b10; rd_in[1] = 5'd7; writeData_in[1] = 64'hBEEF;
      expect_v(0, 0, 64'hBEEF, "fwd_x7_p1");
      expect_v(1, 0, 64'hDEAD, "nofwd_x7_old");
      step(); idle();
      expect_v(1, 0, 64'hBEEF, "x7_new_nb");
      step();

      // Pending tracking on x3, x4
      issue_valid = 1'b1; issue_rd = 5'd3;
      step();
      issue_rd = 5'd4;
      expect_v(4, 0, 64'd1, "cnt_one");
      step(); idle();
      rs_in[0] = 5'd3; rs_in[1] = 5'd4;
      expect_v(4, 0, 64'd2, "cnt_two");
      expect_v(2, 0, 64'd1, "busy_x3");
      expect_v(2, 1, 64'd1, "busy_x4");
      expect_v(3, 0, 64'd1, "busy_x3_nb");
      step();
      issue_valid = 1'b1; issue_rd = 5'd3;
      regWrite_ctrl = 2'b10; rd_in[1] = 5'd3; writeData_in[1] = 64'h33;
      expect_v(2, 0, 64'd0, "busy_masked");
      expect_v(3, 0, 64'd1, "busy_unmasked");
      expect_v(0, 0, 64'h33, "fwd_x3");
      step(); idle();
      expect_v(2, 0, 64'd1, "issue_wins");
      expect_v(4, 0, 64'd2, "cnt_issue_wins");
      expect_v(0, 0, 64'h33, "x3_rd");
      step();
      regWrite_ctrl = 2'b01; rd_in[0] = 5'd4; writeData_in[0] = 64'h44;
      expect_v(2, 1, 64'd0, "busy_x4_masked");
      expect_v(3, 1, 64'd1, "busy_x4_nb");
      step(); idle();
      expect_v(4, 0, 64'd1, "cnt_after_x4");
      expect_v(2, 1, 64'd0, "x4_cleared");
      expect_v(3, 1, 64'd0, "x4_cleared_nb");
      expect_v(2, 0, 64'd1, "x3_still");
      step();

      // x0 ignores writes and issue
      regWrite_ctrl = 2'b01; rd_in[0] = 5'd0; writeData_in[0] = 64'hFFFF;
      issue_valid = 1'b1; issue_rd = 5'd0;
      rs_in[0] = 5'd0; rs_in[1] = 5'd0;
      expect_v(0, 0, 64'h0, "x0_nofwd");
      expect_v(2, 0, 64'd0, "x0_busy");
      step(); idle();
      expect_v(0, 0, 64'h0, "x0_rd");
      expect_v(1, 1, 64'h0, "x0_rd_nb");
      expect_v(4, 0, 64'd1, "x0_cnt");
      step();

      // Reset discards x9 pending state and data
      issue_valid = 1'b1; issue_rd = 5'd9;
      regWrite_ctrl = 2'b01; rd_in[0] = 5'd9; writeData_in[0] = 64'h55;
      step(); idle();
      rs_in[0] = 5'd9; rs_in[1] = 5'd3;
      expect_v(0, 0, 64'h55, "x9_rd");
      expect_v(2, 0, 64'd1, "x9_busy");
      expect_v(4, 0, 64'd2, "x9_cnt");
      step();
      reset = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd9;
      regWrite_ctrl = 2'b01; rd_in[0] = 5'd9; writeData_in[0] = 64'h77;
      step();
      reset = 1'b0; idle();
      expect_v(0, 0, 64'h0, "mrst_x9");
      expect_v(1, 0, 64'h0, "mrst_x9_nb");
      expect_v(0, 1, 64'h0, "mrst_x3");
      expect_v(2, 0, 64'd0, "mrst_busy9");
      expect_v(2, 1, 64'd0, "mrst_busy3");
      expect_v(4, 0, 64'd0, "mrst_cnt");
      #1;
      total++;
      if (cnt_b !== 6'd0 || busy_b !== 2'b00 || rdata_b[0] !== 64'h0)
         $display("FAIL direct_mrst: cnt=%0d busy=%b x9=0x%0h", cnt_b, busy_b, rdata_b[0]);
      else
         passed++;
      step();
      regWrite_ctrl = 2'b10; rd_in[1] = 5'd9; writeData_in[1] = 64'h66;
      expect_v(4, 0, 64'd0, "post_rst_cnt");
      step(); idle();
      expect_v(0, 0, 64'h66, "post_rst_x9");
      expect_v(1, 0, 64'h66, "post_rst_x9_nb");
      expect_v(2, 0, 64'd0, "post_rst_busy");
      step();

      for (int w = 0; w < 5 && exp_q.size() > 0; w++) step();
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         total++;
         $display("FAIL %s: never compared, expected 0x%0h", e.name, e.val);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH_POW, default 6, log2 of data width.
REQ-002 SHALL have parameter DATA_WIDTH, default 1<<DATA_WIDTH_POW, register width in bits.
REQ-003 SHALL have parameter REG_COUNT, default 32, number of architectural registers (2..64).
REQ-004 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter NUM_WR, default 2, number of write ports (1..3).
REQ-006 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-007 SHALL use one clock and a synchronous, active-high reset: clk_in and reset.
REQ-008 Ports SHALL be: clk_in in 1 clock; reset in 1 sync active-high reset; regWrite_ctrl in NUM_WR per-port write enable; rd_in in NUM_WR x ADDR_W write index; writeData_in in NUM_WR x DATA_WIDTH write data; rs_in in NUM_RD x ADDR_W read index; regData_out out NUM_RD x DATA_WIDTH read data; issue_valid in 1 mark destination pending; issue_rd in ADDR_W pending destination; busy_out out NUM_RD register-at-rs pending; pending_count_out out CNT_W number of pending registers.
REQ-009 ADDR_W SHALL be clog2(REG_COUNT); CNT_W SHALL be clog2(REG_COUNT+1).

Function
REQ-010 Register 0 SHALL read as zero, ignore writes, and never be pending.
REQ-011 Write port i SHALL update register rd_in[i] at posedge when regWrite_ctrl[i]=1, rd_in[i]!=0 and rd_in[i]<REG_COUNT.
REQ-012 When several ports write the same register in one cycle, the highest-index port SHALL win.
REQ-013 Reads SHALL be combinational; indices >=REG_COUNT SHALL read zero.
REQ-014 With BYPASS=1, a read matching a same-cycle valid write SHALL return that write data (highest-index port on conflict); with BYPASS=0 it SHALL return the stored value.
REQ-015 A per-register busy bit SHALL be set at posedge by issue_valid with issue_rd!=0 and in range.
REQ-016 A busy bit SHALL be cleared at posedge by any valid write to that register.
REQ-017 Simultaneous issue and write to the same register SHALL leave it busy (issue wins).
REQ-018 busy_out[j] SHALL equal busy[rs_in[j]], masked to 0 when BYPASS=1 and a same-cycle valid write targets rs_in[j].
REQ-019 pending_count_out SHALL be a registered count equal to the population of busy bits after every edge, never wrapping.

Reset
REQ-020 When reset=1 at posedge, every register and busy bit SHALL become zero, overriding writes and issue in that cycle.
REQ-021 After reset, regData_out SHALL be 0 for every index and busy_out and pending_count_out SHALL be 0.
REQ-022 Reset asserted mid-sequence SHALL discard all pending state; the first post-reset write SHALL behave as from power-up.

Structure
REQ-023 Package regfile_pkg SHALL hold the ADDR_W/CNT_W derivation functions and default parameter constants.
REQ-024 Busy tracking and the pending counter SHALL be sub-module regfile_scoreboard, instantiated once.

Verification
REQ-025 Reset, then read all indices on all ports -> every regData_out=0, pending_count_out=0.
REQ-026 Port0 writes x5=0xA5A5, port1 writes x5=0x1234 same cycle -> next cycle rs=5 reads 0x1234.
REQ-027 BYPASS=1: write x7=0xDEAD while rs_in[0]=7 -> regData_out[0]=0xDEAD in the same cycle; BYPASS=0 -> old value.
REQ-028 Write x0=0xFFFF and issue_rd=0 -> x0 reads 0, pending_count_out unchanged.
REQ-029 Issue x3, x4 -> count=2; write x3 while issuing x3 -> x3 still busy, count=2; write x4 -> count=1.
REQ-030 Issue x9 and write x9=0x55, then assert reset with a write to x9 -> x9 reads 0, busy_out=0, count=0.
